// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC controller: bus width, instruction step and
// the fetch FSM state encoding.
package pc_ctrl_pkg;

   localparam int unsigned PC_W      = 32;
   localparam int unsigned INST_STEP = 4;

   typedef enum logic [1:0] {
      ST_INIT       = 2'd0,
      ST_FETCH      = 2'd1,
      ST_REDIR_WAIT = 2'd2
   } state_e;

endpackage : pc_ctrl_pkg

// File: rtl/pc_redir_mux.sv
// Redirect priority select: trap beats branch, branch beats jump.
module pc_redir_mux #(
   parameter int unsigned PC_WIDTH = 32
) (
   input  logic                trap_valid_i,
   input  logic [PC_WIDTH-1:0] trap_vector_i,
   input  logic                br_taken_i,
   input  logic [PC_WIDTH-1:0] br_target_i,
   input  logic                jmp_valid_i,
   input  logic [PC_WIDTH-1:0] jmp_target_i,
   output logic                redir_o,
   output logic [PC_WIDTH-1:0] redir_tgt_o
);

   always_comb begin
      // NOTE: every output gets a default before the ifs, so no latch is inferred.
      redir_o     = trap_valid_i | br_taken_i | jmp_valid_i;
      redir_tgt_o = jmp_target_i;
      if (br_taken_i)   redir_tgt_o = br_target_i;
      if (trap_valid_i) redir_tgt_o = trap_vector_i;
   end

endmodule : pc_redir_mux

// File: rtl/pc_ctrl.sv
// Next-PC and fetch-request control: sequential stepping, prioritized redirects
// and redirects that arrive while an instruction fetch is still outstanding.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int unsigned          PC_WIDTH = PC_W,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PC_WIDTH-1:0] pc_i,
   output logic [PC_WIDTH-1:0] pc_next_o,
   output logic                pc_stall_o,
   input  logic                stall_i,
   input  logic                trap_valid_i,
   input  logic [PC_WIDTH-1:0] trap_vector_i,
   input  logic                br_taken_i,
   input  logic [PC_WIDTH-1:0] br_target_i,
   input  logic                jmp_valid_i,
   input  logic [PC_WIDTH-1:0] jmp_target_i,
   output logic                ifu_req_o,
   output logic [PC_WIDTH-1:0] ifu_addr_o,
   input  logic                ifu_ack_i,
   output logic                inst_valid_o,
   output logic                flush_o
);

   // The first fetch address must be instruction aligned.
   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("pc_ctrl: RESET_PC must be 4-byte aligned");
   end

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pend_q, pend_d;
   logic                redir;
   logic [PC_WIDTH-1:0] redir_tgt;
   logic [PC_WIDTH-1:0] pc_seq;

   pc_redir_mux #(.PC_WIDTH(PC_WIDTH)) u_redir_mux (
      .trap_valid_i (trap_valid_i),
      .trap_vector_i(trap_vector_i),
      .br_taken_i   (br_taken_i),
      .br_target_i  (br_target_i),
      .jmp_valid_i  (jmp_valid_i),
      .jmp_target_i (jmp_target_i),
      .redir_o      (redir),
      .redir_tgt_o  (redir_tgt)
   );

   assign pc_seq     = pc_i + PC_WIDTH'(INST_STEP);
   assign ifu_addr_o = pc_i;

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      pc_next_o    = pc_seq;
      pc_stall_o   = 1'b1;
      inst_valid_o = 1'b0;
      flush_o      = 1'b0;
      ifu_req_o    = 1'b0;
      // While reset is held every output sits at its idle value, whatever the inputs do.
      if (rst_n) begin
         unique case (state_q)
            ST_INIT: begin
               state_d = ST_FETCH;
               if (redir) begin
                  pc_next_o  = redir_tgt;
                  pc_stall_o = 1'b0;
                  flush_o    = 1'b1;
               end
            end
            ST_FETCH: begin
               ifu_req_o = 1'b1;
               if (redir) begin
                  flush_o = 1'b1;
                  if (ifu_ack_i) begin
                     pc_next_o  = redir_tgt;
                     pc_stall_o = 1'b0;
                  end else begin
                     // Address must stay put until the outstanding fetch completes.
                     pend_d  = redir_tgt;
                     state_d = ST_REDIR_WAIT;
                  end
               end else if (ifu_ack_i && !stall_i) begin
                  pc_stall_o   = 1'b0;
                  inst_valid_o = 1'b1;
               end
            end
            ST_REDIR_WAIT: begin
               ifu_req_o = 1'b1;
               flush_o   = redir;
               if (redir) pend_d = redir_tgt;
               if (ifu_ack_i) begin
                  pc_next_o  = redir ? redir_tgt : pend_q;
                  pc_stall_o = 1'b0;
                  state_d    = ST_FETCH;
               end
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   // NOTE: asynchronous reset is in the sensitivity list so it acts without a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         pend_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

endmodule : pc_ctrl

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_i;
   logic [31:0] pc_next_o;
   logic        pc_stall_o;
   logic        stall_i;
   logic        trap_valid_i;
   logic [31:0] trap_vector_i;
   logic        br_taken_i;
   logic [31:0] br_target_i;
   logic        jmp_valid_i;
   logic [31:0] jmp_target_i;
   logic        ifu_req_o;
   logic [31:0] ifu_addr_o;
   logic        ifu_ack_i;
   logic        inst_valid_o;
   logic        flush_o;

   pc_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_i         (pc_i),
      .pc_next_o    (pc_next_o),
      .pc_stall_o   (pc_stall_o),
      .stall_i      (stall_i),
      .trap_valid_i (trap_valid_i),
      .trap_vector_i(trap_vector_i),
      .br_taken_i   (br_taken_i),
      .br_target_i  (br_target_i),
      .jmp_valid_i  (jmp_valid_i),
      .jmp_target_i (jmp_target_i),
      .ifu_req_o    (ifu_req_o),
      .ifu_addr_o   (ifu_addr_o),
      .ifu_ack_i    (ifu_ack_i),
      .inst_valid_o (inst_valid_o),
      .flush_o      (flush_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      bit          chk_next;
      logic [31:0] nxt;
      logic [31:0] addr;
      logic        stall;
      logic        valid;
      logic        flush;
      logic        req;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_errs   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errs++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.chk_next) check({e.nm, ".pc_next"}, pc_next_o, e.nxt);
         check({e.nm, ".addr"},  ifu_addr_o,           e.addr);
         check({e.nm, ".stall"}, {31'd0, pc_stall_o},   {31'd0, e.stall});
         check({e.nm, ".valid"}, {31'd0, inst_valid_o}, {31'd0, e.valid});
         check({e.nm, ".flush"}, {31'd0, flush_o},      {31'd0, e.flush});
         check({e.nm, ".req"},   {31'd0, ifu_req_o},    {31'd0, e.req});
      end
   end

   task automatic drive(input logic [31:0] pc, input logic ack, input logic stl);
      pc_i         = pc;
      ifu_ack_i    = ack;
      stall_i      = stl;
      trap_valid_i = 1'b0;
      br_taken_i   = 1'b0;
      jmp_valid_i  = 1'b0;
   endtask

   // Push the expectation for the inputs currently driven, then advance one cycle.
   task automatic expect_cyc(input string nm, input bit cn, input logic [31:0] nxt,
                             input logic stall, input logic valid, input logic flush,
                             input logic req);
      exp_t x;
      x.nm = nm; x.chk_next = cn; x.nxt = nxt; x.addr = pc_i;
      x.stall = stall; x.valid = valid; x.flush = flush; x.req = req;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      trap_vector_i = 32'h0; br_target_i = 32'h0; jmp_target_i = 32'h0;
      drive(32'h0, 1'b1, 1'b0);
      @(posedge clk);
      #1;

      // Held in reset with a trap pending: outputs stay idle, no flush.
      trap_valid_i = 1'b1; trap_vector_i = 32'h80;
      expect_cyc("reset", 1, 32'h4, 1, 0, 0, 0);

      // Release: one INIT cycle, then sequential fetch with ack tied high.
      rst_n = 1'b1;
      drive(32'h0, 1'b1, 1'b0);
      expect_cyc("init", 1, 32'h4, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(32'(i * 4), 1'b1, 1'b0);
         expect_cyc($sformatf("seq%0d", i), 1, 32'(i * 4 + 4), 0, 1, 0, 1);
      end

      // Ack delayed three cycles at 0x100.
      for (int i = 0; i < 3; i++) begin
         drive(32'h100, 1'b0, 1'b0);
         expect_cyc($sformatf("wait%0d", i), 0, 32'h0, 1, 0, 0, 1);
      end
      drive(32'h100, 1'b1, 1'b0);
      expect_cyc("late_ack", 1, 32'h104, 0, 1, 0, 1);

      // Priority: trap over branch over jump.
      drive(32'h104, 1'b1, 1'b0);
      trap_valid_i = 1'b1; trap_vector_i = 32'h80;
      br_taken_i = 1'b1;   br_target_i = 32'h200;
      jmp_valid_i = 1'b1;  jmp_target_i = 32'h300;
      expect_cyc("prio_trap", 1, 32'h80, 0, 0, 1, 1);
      drive(32'h80, 1'b1, 1'b0);
      br_taken_i = 1'b1; jmp_valid_i = 1'b1;
      expect_cyc("prio_br", 1, 32'h200, 0, 0, 1, 1);
      drive(32'h200, 1'b1, 1'b0);
      jmp_valid_i = 1'b1;
      expect_cyc("jmp_only", 1, 32'h300, 0, 0, 1, 1);

      // Redirect while fetch outstanding, overwritten by a later jump.
      drive(32'h300, 1'b0, 1'b0);
      br_taken_i = 1'b1; br_target_i = 32'h400;
      expect_cyc("rw_enter", 0, 32'h0, 1, 0, 1, 1);
      drive(32'h300, 1'b0, 1'b0);
      expect_cyc("rw_hold", 0, 32'h0, 1, 0, 0, 1);
      drive(32'h300, 1'b0, 1'b0);
      jmp_valid_i = 1'b1; jmp_target_i = 32'h500;
      expect_cyc("rw_over", 0, 32'h0, 1, 0, 1, 1);
      drive(32'h300, 1'b1, 1'b0);
      expect_cyc("rw_ack", 1, 32'h500, 0, 0, 0, 1);
      drive(32'h500, 1'b1, 1'b0);
      expect_cyc("rw_back", 1, 32'h504, 0, 1, 0, 1);

      // Hazard stall, then a branch overriding it.
      drive(32'h20, 1'b1, 1'b1);
      expect_cyc("stall", 0, 32'h0, 1, 0, 0, 1);
      drive(32'h20, 1'b1, 1'b1);
      br_taken_i = 1'b1; br_target_i = 32'h40;
      expect_cyc("stall_br", 1, 32'h40, 0, 0, 1, 1);

      // Wrap-around of the sequential PC.
      drive(32'hFFFF_FFFC, 1'b1, 1'b0);
      expect_cyc("wrap", 1, 32'h0, 0, 1, 0, 1);

      // Asynchronous reset while in REDIR_WAIT.
      drive(32'h40, 1'b0, 1'b0);
      br_taken_i = 1'b1; br_target_i = 32'h600;
      expect_cyc("rw2_enter", 0, 32'h0, 1, 0, 1, 1);
      rst_n = 1'b0;
      drive(32'h40, 1'b0, 1'b0);
      expect_cyc("rst_in_rw", 1, 32'h44, 1, 0, 0, 0);

      // INIT with a redirect, then normal fetch (stale response ignored).
      rst_n = 1'b1;
      drive(32'h0, 1'b1, 1'b0);
      jmp_valid_i = 1'b1; jmp_target_i = 32'h700;
      expect_cyc("init_redir", 1, 32'h700, 0, 0, 1, 0);
      drive(32'h700, 1'b1, 1'b0);
      expect_cyc("after_init", 1, 32'h704, 0, 1, 0, 1);

      drive(32'h704, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_errs++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule : tb_pc_ctrl
